// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchroniser, debounce and press/auto-repeat events for four buttons
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [3:0] raw;
  assign raw = {btn_down, btn_up, btn_right, btn_left};

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          level_q;
    logic [DW-1:0] db_cnt;
    logic          rise;
    logic          fall;
    state_t        state_q;
    state_t        state_d;
    logic [RW-1:0] rcnt_q;
    logic [RW-1:0] rcnt_d;
    logic          press_q;
    logic          press_d;
    logic          release_q;
    logic          release_d;

    // Two-flop synchroniser for the asynchronous raw pin
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
      end
    end

    // Debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_q <= 1'b0;
        db_cnt  <= '0;
      end else if (s2 == level_q) begin
        db_cnt  <= '0;
      end else if (db_cnt == DB_LAST) begin
        level_q <= ~level_q;
        db_cnt  <= '0;
      end else begin
        db_cnt  <= db_cnt + DW'(1);
      end
    end

    // Decoded on the same edge the level toggles so the event pulse lines up with the level
    assign rise = (s2 != level_q) && (db_cnt == DB_LAST) && !level_q;
    assign fall = (s2 != level_q) && (db_cnt == DB_LAST) && level_q;

    // Event FSM state, repeat counter and registered pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= ST_IDLE;
        rcnt_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        rcnt_q    <= rcnt_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Event FSM next state: a fall always wins over a terminal-count repeat
    always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          rcnt_d = '0;
          if (rise) begin
            press_d = 1'b1;
            state_d = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (fall) begin
            release_d = 1'b1;
            rcnt_d    = '0;
            state_d   = ST_IDLE;
          end else if (rcnt_q == DELAY_LAST) begin
            press_d = 1'b1;
            rcnt_d  = '0;
            state_d = ST_REPEAT;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        ST_REPEAT: begin
          if (fall) begin
            release_d = 1'b1;
            rcnt_d    = '0;
            state_d   = ST_IDLE;
          end else if (rcnt_q == PERIOD_LAST) begin
            press_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        default: begin
          rcnt_d  = '0;
          state_d = ST_IDLE;
        end
      endcase
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                            input logic [3:0] rel);
    check_eq({tag, ".level"}, {28'd0, btn_level}, {28'd0, lvl});
    check_eq({tag, ".press"}, {28'd0, btn_press}, {28'd0, prs});
    check_eq({tag, ".release"}, {28'd0, btn_release}, {28'd0, rel});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [3:0] v);
    {btn_down, btn_up, btn_right, btn_left} = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_btns(4'b0000);
    repeat (3) tick();
    check_outs("reset", 4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    int jp;

    // Scenario 1: reset with left held, re-detected on edge 6 after release
    rst_n = 1'b0;
    set_btns(4'b0001);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_outs("s1_in_reset", 4'b0000, 4'b0000, 4'b0000);
    end
    rst_n = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      lvl = (j >= 6) ? 4'b0001 : 4'b0000;
      prs = (j == 6) ? 4'b0001 : 4'b0000;
      check_outs("s1_first_press", lvl, prs, 4'b0000);
    end

    // Scenario 2: bounce on up (3 high / 1 low) is rejected, then a stable hold
    do_reset();
    for (int k = 0; k < 40; k++) begin
      btn_up = ((k % 4) != 3);
      tick();
      check_outs("s2_bounce", 4'b0000, 4'b0000, 4'b0000);
    end
    for (int j = 1; j <= 8; j++) begin
      btn_up = 1'b1;
      tick();
      lvl = (j >= 6) ? 4'b0100 : 4'b0000;
      prs = (j == 6) ? 4'b0100 : 4'b0000;
      check_outs("s2_stable", lvl, prs, 4'b0000);
    end

    // Scenario 3: auto-repeat on right at P, P+10, P+13, ...
    do_reset();
    for (int j = 1; j <= 45; j++) begin
      btn_right = 1'b1;
      tick();
      jp  = j - 6;
      lvl = (j >= 6) ? 4'b0010 : 4'b0000;
      prs = ((jp == 0) || (jp >= RD && ((jp - RD) % RP) == 0)) ? 4'b0010 : 4'b0000;
      check_outs("s3_repeat", lvl, prs, 4'b0000);
    end

    // Scenario 4: down's fall lands on a repeat edge (j=19), then a fresh press
    do_reset();
    for (int j = 1; j <= 42; j++) begin
      btn_down = (j <= 13) || (j >= 26);
      tick();
      lvl = ((j >= 6 && j < 19) || j >= 31) ? 4'b1000 : 4'b0000;
      prs = (j == 6 || j == 16 || j == 31 || j == 41) ? 4'b1000 : 4'b0000;
      rel = (j == 19) ? 4'b1000 : 4'b0000;
      check_outs("s4_release_tc", lvl, prs, rel);
    end

    // Scenario 5: left and right together, right released, left keeps repeating
    do_reset();
    for (int j = 1; j <= 28; j++) begin
      btn_left  = 1'b1;
      btn_right = (j < 12);
      tick();
      lvl = 4'b0000;
      prs = 4'b0000;
      rel = 4'b0000;
      lvl[0] = (j >= 6);
      lvl[1] = (j >= 6 && j < 17);
      prs[0] = (j == 6 || j == 16 || j == 19 || j == 22 || j == 25 || j == 28);
      prs[1] = (j == 6 || j == 16);
      rel[1] = (j == 17);
      check_outs("s5_simul", lvl, prs, rel);
    end

    // Scenario 6: asynchronous reset between edges while left is repeating
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("s6_async", 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      tick();
      check_outs("s6_held_reset", 4'b0000, 4'b0000, 4'b0000);
    end
    rst_n = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tick();
      lvl = (j >= 6) ? 4'b0001 : 4'b0000;
      prs = (j == 6) ? 4'b0001 : 4'b0000;
      check_outs("s6_repress", lvl, prs, 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
